// File: rtl/pifo_buf_alloc_if.sv
// Handshake bundle between the PIFO buffer allocator, its requesters and the address free list.
// The slave modport is the allocator's view; the master modport is the surrounding logic's view.
interface pifo_buf_alloc_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 2
);
  logic                  o__alloc_valid;
  logic [ADDR_WIDTH-1:0] o__alloc_addr;
  logic                  i__alloc_ready;
  logic                  i__free_valid;
  logic [ADDR_WIDTH-1:0] i__free_addr;
  logic                  o__free_ready;
  logic                  i__fl_out_valid;
  logic [ADDR_WIDTH-1:0] i__fl_out_data;
  logic                  o__fl_out_ready;
  logic                  o__fl_in_valid;
  logic [ADDR_WIDTH-1:0] o__fl_in_data;
  logic                  i__fl_in_ready;
  logic [CNT_WIDTH-1:0]  o__occupancy;
  logic                  o__err_double_free;
  logic                  o__err_bad_addr;

  modport slave (
    output o__alloc_valid, o__alloc_addr, o__free_ready, o__fl_out_ready,
           o__fl_in_valid, o__fl_in_data, o__occupancy, o__err_double_free, o__err_bad_addr,
    input  i__alloc_ready, i__free_valid, i__free_addr, i__fl_out_valid, i__fl_out_data,
           i__fl_in_ready
  );

  modport master (
    input  o__alloc_valid, o__alloc_addr, o__free_ready, o__fl_out_ready,
           o__fl_in_valid, o__fl_in_data, o__occupancy, o__err_double_free, o__err_bad_addr,
    output i__alloc_ready, i__free_valid, i__free_addr, i__fl_out_valid, i__fl_out_data,
           i__fl_in_ready
  );
endinterface

// File: rtl/pifo_buf_alloc.sv
// Buffer-address allocator between the free-list FIFO and the PIFO enqueue path: prefetches
// free addresses, returns freed ones, and tracks the allocated bitmap, occupancy and free errors.
module pifo_buf_alloc #(
  parameter int unsigned     DEPTH      = 3,
  parameter longint unsigned INIT_VAL   = 0,
  parameter int unsigned     ADDR_WIDTH = 64,
  parameter int unsigned     CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input logic             w__init_clk,
  input logic             reset,
  pifo_buf_alloc_if.slave bus
);

  typedef enum logic {
    WAIT_FL = 1'b0,
    RUN     = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(INIT_VAL);

  state_t                r_state;
  logic                  r_pf_valid;
  logic [ADDR_WIDTH-1:0] r_pf_data;
  logic                  r_ret_valid;
  logic [ADDR_WIDTH-1:0] r_ret_data;
  logic [DEPTH-1:0]      r_bitmap;
  logic [CNT_WIDTH-1:0]  r_occ;
  logic                  r_err_double_free;
  logic                  r_err_bad_addr;

  logic                  w_run;
  logic                  w_fl_out_ready;
  logic                  w_pop;
  logic                  w_alloc_fire;
  logic                  w_free_ready;
  logic                  w_free_fire;
  logic [ADDR_WIDTH-1:0] w_alloc_idx;
  logic [ADDR_WIDTH-1:0] w_free_idx;
  logic                  w_free_in_range;
  logic                  w_free_hit;
  logic                  w_free_good;
  logic [DEPTH-1:0]      w_alloc_onehot;
  logic [DEPTH-1:0]      w_free_onehot;

  assign w_run          = (r_state == RUN);
  assign w_fl_out_ready = w_run && (!r_pf_valid || bus.i__alloc_ready);
  assign w_pop          = bus.i__fl_out_valid && w_fl_out_ready;
  assign w_alloc_fire   = r_pf_valid && bus.i__alloc_ready;
  assign w_free_ready   = w_run && (!r_ret_valid || bus.i__fl_in_ready);
  assign w_free_fire    = bus.i__free_valid && w_free_ready;

  // Unsigned subtraction: addresses below the base wrap to huge indices and fail the range test.
  assign w_alloc_idx     = r_pf_data - BASE;
  assign w_free_idx      = bus.i__free_addr - BASE;
  assign w_free_in_range = (w_free_idx < ADDR_WIDTH'(DEPTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_alloc_onehot = '0;
    w_free_onehot  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_alloc_onehot[i] = (w_alloc_idx == ADDR_WIDTH'(i));
      w_free_onehot[i]  = (w_free_idx == ADDR_WIDTH'(i));
    end
  end

  assign w_free_hit  = |(r_bitmap & w_free_onehot);
  assign w_free_good = w_free_fire && w_free_in_range && w_free_hit;

  assign bus.o__alloc_valid     = r_pf_valid;
  assign bus.o__alloc_addr      = r_pf_data;
  assign bus.o__free_ready      = w_free_ready;
  assign bus.o__fl_out_ready    = w_fl_out_ready;
  assign bus.o__fl_in_valid     = r_ret_valid;
  assign bus.o__fl_in_data      = r_ret_data;
  assign bus.o__occupancy       = r_occ;
  assign bus.o__err_double_free = r_err_double_free;
  assign bus.o__err_bad_addr    = r_err_bad_addr;

  // NOTE: sequential state uses non-blocking assignments so all registers update off the same edge.
  always_ff @(posedge w__init_clk) begin
    if (reset) begin
      r_state           <= WAIT_FL;
      r_pf_valid        <= 1'b0;
      r_pf_data         <= '0;
      r_ret_valid       <= 1'b0;
      r_ret_data        <= '0;
      // NOTE: the bitmap is small flop state, not RAM, so it is cleared by reset.
      r_bitmap          <= '0;
      r_occ             <= '0;
      r_err_double_free <= 1'b0;
      r_err_bad_addr    <= 1'b0;
    end else begin
      // The free list holds valid low while it initialises; first valid means it is ready.
      if (r_state == WAIT_FL && bus.i__fl_out_valid) r_state <= RUN;

      if (w_pop) begin
        r_pf_valid <= 1'b1;
        r_pf_data  <= bus.i__fl_out_data;
      end else if (w_alloc_fire) begin
        r_pf_valid <= 1'b0;
      end

      if (w_free_good) begin
        r_ret_valid <= 1'b1;
        r_ret_data  <= bus.i__free_addr;
      end else if (bus.i__fl_in_ready) begin
        r_ret_valid <= 1'b0;
      end

      // Alloc and free indices never collide: the prefetched address is always unallocated.
      r_bitmap <= (r_bitmap | ({DEPTH{w_alloc_fire}} & w_alloc_onehot))
                & ~({DEPTH{w_free_good}} & w_free_onehot);

      if (w_alloc_fire && !w_free_good)      r_occ <= r_occ + CNT_WIDTH'(1);
      else if (!w_alloc_fire && w_free_good) r_occ <= r_occ - CNT_WIDTH'(1);

      if (w_free_fire && !w_free_in_range)               r_err_bad_addr    <= 1'b1;
      if (w_free_fire && w_free_in_range && !w_free_hit) r_err_double_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pifo_buf_alloc.sv
// Self-checking bench for pifo_buf_alloc: a behavioural free-list model plus scoreboards for the
// alloc and return streams, with one task per scenario.
module tb_pifo_buf_alloc;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned AW    = 64;
  localparam int unsigned CW    = 2;
  localparam logic [AW-1:0] BASE = 64'h10;
  localparam int FL_INIT_CYC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pifo_buf_alloc_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  pifo_buf_alloc #(
    .DEPTH(DEPTH), .INIT_VAL(64'h10), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .w__init_clk(clk),
    .reset      (reset),
    .bus        (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_alloc[$];
  logic [AW-1:0] exp_ret[$];

  // Free-list model: reloads BASE..BASE+DEPTH-1 on reset and holds valid low while initialising.
  logic [AW-1:0] fl_q[$];
  int            fl_init_cnt;
  logic          m_pop, m_push, m_rst;
  logic [AW-1:0] m_pdata;

  initial begin
    bus.i__fl_out_valid = 1'b0;
    bus.i__fl_out_data  = '0;
    fl_init_cnt = FL_INIT_CYC;
    forever begin
      @(posedge clk);
      m_rst   = reset;
      m_pop   = bus.i__fl_out_valid && bus.o__fl_out_ready;
      m_push  = bus.o__fl_in_valid && bus.i__fl_in_ready;
      m_pdata = bus.o__fl_in_data;
      #1;
      if (m_rst) begin
        fl_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) fl_q.push_back(BASE + AW'(i));
        fl_init_cnt = FL_INIT_CYC;
      end else if (fl_init_cnt > 0) begin
        fl_init_cnt--;
      end else begin
        if (m_pop && fl_q.size() > 0) void'(fl_q.pop_front());
        if (m_push) fl_q.push_back(m_pdata);
      end
      bus.i__fl_out_valid = (fl_init_cnt == 0) && (fl_q.size() > 0);
      bus.i__fl_out_data  = (fl_q.size() > 0) ? fl_q[0] : '0;
    end
  end

  // Scoreboard monitor: compares every alloc fire and every free-list push against expectations.
  logic [AW-1:0] mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && bus.o__alloc_valid && bus.i__alloc_ready) begin
        total++;
        if (exp_alloc.size() == 0) begin
          bad++;
          $display("FAIL alloc_sb: unexpected alloc of addr %0h", bus.o__alloc_addr);
        end else begin
          mon_exp = exp_alloc.pop_front();
          if (bus.o__alloc_addr !== mon_exp) begin
            bad++;
            $display("FAIL alloc_sb: got addr %0h want %0h", bus.o__alloc_addr, mon_exp);
          end
        end
      end
      if (!reset && bus.o__fl_in_valid && bus.i__fl_in_ready) begin
        total++;
        if (exp_ret.size() == 0) begin
          bad++;
          $display("FAIL ret_sb: unexpected free-list push of %0h", bus.o__fl_in_data);
        end else begin
          mon_exp = exp_ret.pop_front();
          if (bus.o__fl_in_data !== mon_exp) begin
            bad++;
            $display("FAIL ret_sb: got addr %0h want %0h", bus.o__fl_in_data, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic chk_val(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_bit({tag, "_alloc_valid"}, bus.o__alloc_valid, 1'b0);
    chk_val({tag, "_alloc_addr"}, bus.o__alloc_addr, '0);
    chk_bit({tag, "_fl_in_valid"}, bus.o__fl_in_valid, 1'b0);
    chk_val({tag, "_fl_in_data"}, bus.o__fl_in_data, '0);
    chk_val({tag, "_occupancy"}, AW'(bus.o__occupancy), '0);
    chk_bit({tag, "_err_df"}, bus.o__err_double_free, 1'b0);
    chk_bit({tag, "_err_bad"}, bus.o__err_bad_addr, 1'b0);
    chk_bit({tag, "_free_ready"}, bus.o__free_ready, 1'b0);
    chk_bit({tag, "_fl_out_ready"}, bus.o__fl_out_ready, 1'b0);
  endtask

  task automatic wait_alloc_valid(input string name, input int budget);
    for (int i = 0; i < budget && bus.o__alloc_valid !== 1'b1; i++) @(negedge clk);
    chk_bit({name, "_timeout"}, bus.o__alloc_valid, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i__alloc_ready = 1'b0;
    bus.i__free_valid  = 1'b0;
    bus.i__free_addr   = '0;
    bus.i__fl_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_wait_fl();
    for (int i = 0; i < 20 && bus.i__fl_out_valid !== 1'b1; i++) begin
      @(negedge clk);
      chk_bit("wait_fl_no_pop", bus.o__fl_out_ready, 1'b0);
    end
    chk_bit("wait_fl_timeout", bus.i__fl_out_valid, 1'b1);
    chk_bit("wait_fl_alloc_low", bus.o__alloc_valid, 1'b0);
    @(negedge clk);
    chk_bit("run_fl_out_ready", bus.o__fl_out_ready, 1'b1);
    chk_bit("run_alloc_still_low", bus.o__alloc_valid, 1'b0);
    @(negedge clk);
    chk_bit("first_alloc_valid", bus.o__alloc_valid, 1'b1);
    chk_val("first_alloc_addr", bus.o__alloc_addr, BASE);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < int'(DEPTH); k++) exp_alloc.push_back(BASE + AW'(k));
    bus.i__alloc_ready = 1'b1;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      @(negedge clk);
      chk_val("b2b_occupancy", AW'(bus.o__occupancy), AW'(k));
    end
    chk_bit("b2b_drained", bus.o__alloc_valid, 1'b0);
    bus.i__alloc_ready = 1'b0;
    chk_val("b2b_sb_empty", AW'(exp_alloc.size()), '0);
  endtask

  task automatic test_free_return();
    bus.i__free_valid = 1'b1;
    bus.i__free_addr  = BASE + 1;
    exp_ret.push_back(BASE + 1);
    chk_bit("free_ready", bus.o__free_ready, 1'b1);
    @(negedge clk);
    bus.i__free_valid = 1'b0;
    chk_bit("ret_valid", bus.o__fl_in_valid, 1'b1);
    chk_val("ret_data", bus.o__fl_in_data, BASE + 1);
    chk_val("ret_occupancy", AW'(bus.o__occupancy), AW'(2));
    wait_alloc_valid("realloc", 8);
    chk_val("realloc_addr", bus.o__alloc_addr, BASE + 1);
  endtask

  task automatic test_simultaneous();
    exp_alloc.push_back(BASE + 1);
    exp_ret.push_back(BASE);
    bus.i__alloc_ready = 1'b1;
    bus.i__free_valid  = 1'b1;
    bus.i__free_addr   = BASE;
    @(negedge clk);
    bus.i__alloc_ready = 1'b0;
    bus.i__free_valid  = 1'b0;
    chk_val("simul_occupancy", AW'(bus.o__occupancy), AW'(2));
    chk_bit("simul_ret_valid", bus.o__fl_in_valid, 1'b1);
    chk_val("simul_ret_data", bus.o__fl_in_data, BASE);
    chk_bit("simul_pf_empty", bus.o__alloc_valid, 1'b0);
    wait_alloc_valid("simul_recycle", 8);
    chk_val("simul_recycle_addr", bus.o__alloc_addr, BASE);
  endtask

  task automatic test_errors();
    bus.i__free_valid = 1'b1;
    bus.i__free_addr  = BASE + 1;
    exp_ret.push_back(BASE + 1);
    @(negedge clk);
    chk_val("err_first_free_occ", AW'(bus.o__occupancy), AW'(1));
    chk_bit("err_first_free_push", bus.o__fl_in_valid, 1'b1);
    chk_bit("err_df_before", bus.o__err_double_free, 1'b0);
    @(negedge clk);
    chk_bit("err_double_free", bus.o__err_double_free, 1'b1);
    chk_bit("err_df_no_push", bus.o__fl_in_valid, 1'b0);
    chk_val("err_df_occ", AW'(bus.o__occupancy), AW'(1));
    chk_bit("err_bad_before", bus.o__err_bad_addr, 1'b0);
    bus.i__free_addr = 64'h20;
    @(negedge clk);
    chk_bit("err_bad_addr", bus.o__err_bad_addr, 1'b1);
    chk_val("err_bad_occ", AW'(bus.o__occupancy), AW'(1));
    chk_bit("err_bad_no_push", bus.o__fl_in_valid, 1'b0);
    // The prefetched address (cleared in the simultaneous cycle) is unallocated.
    bus.i__free_addr = BASE;
    @(negedge clk);
    chk_val("free_prefetched_occ", AW'(bus.o__occupancy), AW'(1));
    chk_bit("free_prefetched_no_push", bus.o__fl_in_valid, 1'b0);
    bus.i__free_addr = BASE + 2;
    exp_ret.push_back(BASE + 2);
    @(negedge clk);
    chk_val("top_slot_occ", AW'(bus.o__occupancy), AW'(0));
    chk_bit("top_slot_push", bus.o__fl_in_valid, 1'b1);
    chk_val("top_slot_data", bus.o__fl_in_data, BASE + 2);
    bus.i__free_addr = BASE + 3;
    @(negedge clk);
    bus.i__free_valid = 1'b0;
    chk_val("past_top_occ", AW'(bus.o__occupancy), AW'(0));
    chk_bit("past_top_no_push", bus.o__fl_in_valid, 1'b0);
  endtask

  task automatic test_stall_reset();
    exp_alloc.push_back(BASE);
    bus.i__alloc_ready = 1'b1;
    @(negedge clk);
    bus.i__alloc_ready = 1'b0;
    chk_val("stall_occ_alloc", AW'(bus.o__occupancy), AW'(1));
    chk_val("stall_next_pf", bus.o__alloc_addr, BASE + 1);
    bus.i__fl_in_ready = 1'b0;
    bus.i__free_valid  = 1'b1;
    bus.i__free_addr   = BASE;
    @(negedge clk);
    chk_val("stall_occ_free", AW'(bus.o__occupancy), AW'(0));
    for (int k = 0; k < 3; k++) begin
      chk_bit("stall_free_ready", bus.o__free_ready, 1'b0);
      chk_bit("stall_ret_valid", bus.o__fl_in_valid, 1'b1);
      chk_val("stall_ret_data", bus.o__fl_in_data, BASE);
      @(negedge clk);
    end
    bus.i__free_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    bus.i__fl_in_ready = 1'b1;
    @(negedge clk);
    chk_bit("post_reset_wait_fl", bus.o__fl_out_ready, 1'b0);
    wait_alloc_valid("post_reset_alloc", 20);
    chk_val("post_reset_addr", bus.o__alloc_addr, BASE);
  endtask

  initial begin
    test_reset();
    test_wait_fl();
    test_back_to_back();
    test_free_return();
    test_simultaneous();
    test_errors();
    test_stall_reset();
    repeat (2) @(negedge clk);
    chk_val("final_alloc_sb_empty", AW'(exp_alloc.size()), '0);
    chk_val("final_ret_sb_empty", AW'(exp_ret.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pifo_buf_alloc.md
Name: pifo_buf_alloc

Overview:
- Sits directly downstream of the address free-list FIFO (fifo_init, pre-loaded with INIT_VAL..INIT_VAL+DEPTH-1).
- Hands buffer addresses out to the PIFO enqueue path and returns freed addresses to the free list through the free-list input port.
- Owns a prefetch register and a return register, and tracks the allocated-address bitmap and occupancy.
- Flags double-free and out-of-range frees.

Parameters:
- DEPTH, 3: number of buffer slots; must match the free-list DEPTH.
- INIT_VAL, 0: base address of slot 0; must match the free-list INIT_VAL.
- ADDR_WIDTH, 64: address width on all ports; must match the free-list DATA_WIDTH.
- CNT_WIDTH, $clog2(DEPTH+1): occupancy counter width.

Ports:
- w__init_clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- o__alloc_valid  output  1  prefetched free address available
- o__alloc_addr  output  ADDR_WIDTH  address offered to requester
- i__alloc_ready  input  1  requester takes address this cycle
- i__free_valid  input  1  address being returned
- i__free_addr  input  ADDR_WIDTH  returned address
- o__free_ready  output  1  return accepted this cycle
- i__fl_out_valid  input  1  free-list output valid
- i__fl_out_data  input  ADDR_WIDTH  free-list head address
- o__fl_out_ready  output  1  pop free-list head
- o__fl_in_valid  output  1  push to free list
- o__fl_in_data  output  ADDR_WIDTH  address pushed
- i__fl_in_ready  input  1  free list accepts push
- o__occupancy  output  CNT_WIDTH  addresses currently allocated
- o__err_double_free  output  1  sticky: freed an unallocated address
- o__err_bad_addr  output  1  sticky: freed address outside INIT_VAL..INIT_VAL+DEPTH-1

Behaviour:
- Reset is synchronous and active-high on w__init_clk. Reset values:
  - state = WAIT_FL
  - all outputs valid = 0
  - prefetch register empty, return register empty
  - bitmap all 0, occupancy 0, both error flags 0
- State machine:
  - WAIT_FL: o__free_ready=0, o__fl_out_ready=0. Advance to RUN in the first cycle i__fl_out_valid=1 (the free list holds valid low while it initialises).
  - RUN: normal operation. Returns to WAIT_FL only through reset.
- Prefetch register (alloc path):
  - o__alloc_valid = prefetch valid; o__alloc_addr = prefetch data.
  - In RUN, o__fl_out_ready = !pf_valid || i__alloc_ready.
  - On a pop (fl_out_valid && fl_out_ready), the register loads i__fl_out_data with valid=1 next cycle.
  - On alloc fire without a pop, the register goes empty.
  - Alloc latency: one cycle from free-list head to o__alloc_valid. Back-to-back allocs sustain one per cycle.
- Alloc fire (o__alloc_valid && i__alloc_ready):
  - set bitmap[o__alloc_addr-INIT_VAL]
  - occupancy +1
- Free acceptance:
  - o__free_ready = (state==RUN) && (!ret_valid || i__fl_in_ready).
  - Index = i__free_addr - INIT_VAL, computed at ADDR_WIDTH as an unsigned subtraction.
  - If index >= DEPTH (including underflow wrap): consume, drop, set o__err_bad_addr.
  - Else if bitmap[index]==0: consume, drop, set o__err_double_free.
  - Else: clear bitmap[index], occupancy -1, load return register with i__free_addr.
- Return register:
  - o__fl_in_valid = ret_valid; o__fl_in_data = ret data.
  - Clears on i__fl_in_ready when not reloaded in the same cycle.
  - Free-to-free-list latency: one cycle.
- Simultaneous alloc fire and valid free in one cycle:
  - occupancy unchanged
  - both bitmap updates apply; indices are necessarily distinct because the prefetched address is unallocated
  - freeing the prefetched address itself is a double free
- Occupancy:
  - saturates neither way under legal use; must never exceed DEPTH
  - an alloc fire at occupancy==DEPTH is impossible because the free list is empty
- Error flags: sticky until reset. A dropped free never touches the bitmap, occupancy or return register.
- Reset mid-operation: the prefetch and return contents are discarded. The free list is reset in the same cycle and re-initialises, so no address is lost.

Test Plan:
1. Reset, DEPTH=3, INIT_VAL=0x10; free list presents 0x10 after init.
   -> WAIT_FL until fl_out_valid; o__alloc_valid rises one cycle later with 0x10.
2. i__alloc_ready held high for 3 cycles.
   -> addresses 0x10, 0x11, 0x12 on consecutive cycles; occupancy 1, 2, 3; o__alloc_valid then 0.
3. After test 2, free 0x11.
   -> o__fl_in_valid=1 with 0x11 on the next cycle; occupancy 2; realloc later returns 0x11.
4. Same cycle: alloc fire and free 0x10.
   -> occupancy unchanged; bitmap shows new address set and 0x10 cleared.
5. Free 0x11 twice, then free 0x20.
   -> second free is consumed, o__err_double_free=1, no push; the 0x20 free sets o__err_bad_addr=1, occupancy unchanged.
6. i__fl_in_ready=0 with a pending return.
   -> o__free_ready=0 and the return is held stable. Assert reset mid-stall -> all outputs and occupancy return to 0, state WAIT_FL.
